// File: rtl/rgb_light_scheduler_pkg.sv
// Shared types and constants for the RGB light scheduler.
package rgb_sched_pkg;

  // Controller states: idle colour sequence, requester display, blank gap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Idle colour sequence, {r,g,b}, indexed by the idle step counter (entry 0 is rightmost).
  localparam logic [7:0][2:0] IDLE_COLORS = {
    3'b000, 3'b001, 3'b101, 3'b110, 3'b100, 3'b011, 3'b010, 3'b111
  };

  // Light drive during the gap between displays.
  localparam logic [2:0] RGB_BLANK = 3'b000;

endpackage

// File: rtl/rgb_light_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] ptr_i,
  output logic                    valid_o,
  output logic [$clog2(NREQ)-1:0] winner_o
);

  localparam int IW = $clog2(NREQ);

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    valid_o  = 1'b0;
    winner_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid_o && req_i[(int'(ptr_i) + k) % NREQ]) begin
        valid_o  = 1'b1;
        winner_o = IW'((int'(ptr_i) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/rgb_light_scheduler.sv
// Shares one RGB light between NREQ requesters: round-robin timed displays separated by a
// one-cycle blank gap, and a prescaled 8-step idle colour sequence when nobody is requesting.
module rgb_light_scheduler
  import rgb_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DWELL_W  = 8,
  parameter int IDLE_DIV = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [3*NREQ-1:0]       req_color,
  input  logic [DWELL_W*NREQ-1:0] req_dwell,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [2:0]              rgb
);

  localparam int IW = $clog2(NREQ);
  localparam int PW = (IDLE_DIV > 1) ? $clog2(IDLE_DIV) : 1;

  state_e            state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;   // SHOW cycles remaining after the current one
  logic [PW-1:0]     pre_q, pre_d;        // idle prescaler
  logic [2:0]        idle_q, idle_d;      // idle sequence step
  logic [IW-1:0]     ptr_q, ptr_d;        // round-robin pointer
  logic [IW-1:0]     owner_q, owner_d;
  logic [2:0]        rgb_q, rgb_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;

  logic              arb_valid;
  logic [IW-1:0]     arb_winner;
  logic              launch;
  logic [DWELL_W-1:0] win_dwell;
  logic [2:0]        win_color;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .valid_o  (arb_valid),
    .winner_o (arb_winner)
  );

  assign launch    = arb_valid && (state_q == ST_IDLE || state_q == ST_GAP);
  assign win_dwell = req_dwell[int'(arb_winner)*DWELL_W +: DWELL_W];
  assign win_color = req_color[int'(arb_winner)*3 +: 3];

  // Next-state, counters and registered-output values.
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    pre_d   = pre_q;
    idle_d  = idle_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    rgb_d   = rgb_q;
    grant_d = '0;
    done_d  = '0;

    case (state_q)
      ST_IDLE: begin
        if (!launch) begin
          if (pre_q == PW'(IDLE_DIV - 1)) begin
            pre_d  = '0;
            idle_d = idle_q + 3'd1;
          end else begin
            pre_d = pre_q + PW'(1);
          end
          rgb_d = IDLE_COLORS[idle_d];
        end
      end
      ST_SHOW: begin
        if (dwell_q == '0) begin
          state_d         = ST_GAP;
          rgb_d           = RGB_BLANK;
          done_d[owner_q] = 1'b1;
        end else begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
      ST_GAP: begin
        if (!launch) begin
          state_d = ST_IDLE;
          rgb_d   = IDLE_COLORS[idle_q];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Arbitration overrides the IDLE/GAP handling above; idle step stays frozen.
    if (launch) begin
      state_d             = ST_SHOW;
      grant_d[arb_winner] = 1'b1;
      owner_d             = arb_winner;
      rgb_d               = win_color;
      dwell_d             = (win_dwell == '0) ? '0 : win_dwell - DWELL_W'(1);
      pre_d               = '0;
      ptr_d               = (int'(arb_winner) == NREQ - 1) ? '0 : arb_winner + IW'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= ST_IDLE;
      dwell_q <= '0;
      pre_q   <= '0;
      idle_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      rgb_q   <= IDLE_COLORS[0];
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      pre_q   <= pre_d;
      idle_q  <= idle_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rgb_q   <= rgb_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign owner = owner_q;
  assign rgb   = rgb_q;

endmodule

// File: tb/tb_rgb_light_scheduler.sv
// Self-checking bench: directed literal checks from the test plan plus a randomized run
// compared every cycle against a behavioural model of the scheduler.
module tb_rgb_light_scheduler;

  localparam int NREQ     = 4;
  localparam int DWELL_W  = 8;
  localparam int IDLE_DIV = 4;

  localparam int M_IDLE = 0;
  localparam int M_SHOW = 1;
  localparam int M_GAP  = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req;
  logic [3*NREQ-1:0]       req_color;
  logic [DWELL_W*NREQ-1:0] req_dwell;
  logic [NREQ-1:0]         grant;
  logic [NREQ-1:0]         done;
  logic                    busy;
  logic [1:0]              owner;
  logic [2:0]              rgb;

  always #5 clk = ~clk;

  rgb_light_scheduler #(
    .NREQ     (NREQ),
    .DWELL_W  (DWELL_W),
    .IDLE_DIV (IDLE_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_color (req_color),
    .req_dwell (req_dwell),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .owner     (owner),
    .rgb       (rgb)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Idle colour is a function of how many idle cycles have elapsed in the current idle run,
  // added to the step frozen when the previous run ended.
  logic [2:0] colour_tab [8] = '{3'b111, 3'b010, 3'b011, 3'b100, 3'b110, 3'b101, 3'b001, 3'b000};

  int m_mode, m_left, m_ptr, m_base, m_run, m_owner;
  logic [2:0]      e_rgb;
  logic [NREQ-1:0] e_grant, e_done;
  logic            e_busy;
  bit              model_ok = 1'b0;

  function automatic int cur_step();
    return (m_base + m_run / IDLE_DIV) % 8;
  endfunction

  always @(posedge clk) begin
    e_grant = '0;
    e_done  = '0;
    if (reset) begin
      m_mode = M_IDLE; m_left = 0; m_ptr = 0; m_base = 0; m_run = 0; m_owner = 0;
      e_rgb = 3'b111; e_busy = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (m_mode != M_SHOW && req != '0) begin
        int w;
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
        if (m_mode == M_IDLE) begin
          m_base = cur_step();
          m_run  = 0;
        end
        m_owner    = w;
        m_left     = int'(req_dwell[w*DWELL_W +: DWELL_W]);
        if (m_left == 0) m_left = 1;
        e_rgb      = req_color[w*3 +: 3];
        e_grant[w] = 1'b1;
        e_busy     = 1'b1;
        m_ptr      = (w + 1) % NREQ;
        m_mode     = M_SHOW;
      end else if (m_mode == M_IDLE) begin
        m_run++;
        e_rgb = colour_tab[cur_step()];
      end else if (m_mode == M_SHOW) begin
        m_left--;
        if (m_left == 0) begin
          m_mode = M_GAP;
          e_rgb  = 3'b000;
          e_done[m_owner] = 1'b1;
        end
      end else begin
        m_mode = M_IDLE;
        e_busy = 1'b0;
        e_rgb  = colour_tab[m_base];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("m_grant", 32'(grant), 32'(e_grant));
      check("m_done",  32'(done),  32'(e_done));
      check("m_busy",  32'(busy),  32'(e_busy));
      check("m_owner", 32'(owner), 32'(m_owner));
      check("m_rgb",   32'(rgb),   32'(e_rgb));
    end
  end

  // ---------------- grant / done monitors ----------------
  int g_idx [$];
  int g_cyc [$];
  int cyc_cnt   = 0;
  int done_cnt  = 0;

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    cyc_cnt++;
    if (grant != '0) begin
      g_idx.push_back(onehot_idx(grant));
      g_cyc.push_back(cyc_cnt);
    end
    if (done != '0) done_cnt++;
  end

  // ---------------- stimulus ----------------
  logic [2:0] idle_seq [9] = '{3'b111, 3'b010, 3'b011, 3'b100, 3'b110, 3'b101, 3'b001, 3'b000, 3'b111};

  initial begin
    int snap;
    logic [NREQ-1:0] pend;
    int rate;

    reset = 1'b1; req = '0; req_color = '0; req_dwell = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state and idle sequence, one step every IDLE_DIV cycles.
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    for (int s = 0; s < 9; s++) begin
      check("idle_rgb",  32'(rgb),  32'(idle_seq[s]));
      check("idle_busy", 32'(busy), 32'h0);
      if (s < 8) repeat (IDLE_DIV) @(negedge clk);
    end

    // Single request: requester 2, colour 101, dwell 3.
    req[2] = 1'b1; req_color[8:6] = 3'b101; req_dwell[23:16] = 8'd3;
    @(negedge clk);
    check("one_grant", 32'(grant), 32'h4);
    check("one_owner", 32'(owner), 32'h2);
    check("one_rgb1",  32'(rgb),   32'h5);
    check("one_busy",  32'(busy),  32'h1);
    req = '0;
    @(negedge clk); check("one_rgb2", 32'(rgb), 32'h5); check("one_nogr", 32'(grant), 32'h0);
    @(negedge clk); check("one_rgb3", 32'(rgb), 32'h5);
    @(negedge clk); check("one_gap",  32'(rgb), 32'h0); check("one_done", 32'(done), 32'h4);
    @(negedge clk); check("one_ret",  32'(rgb), 32'h7); check("one_idle", 32'(busy), 32'h0);
    repeat (3) @(negedge clk); check("one_hold", 32'(rgb), 32'h7);
    @(negedge clk); check("one_step", 32'(rgb), 32'h2);

    // Dwell 0 behaves as one cycle.
    req[0] = 1'b1; req_color[2:0] = 3'b110; req_dwell[7:0] = 8'd0;
    @(negedge clk); check("d0_grant", 32'(grant), 32'h1); check("d0_rgb", 32'(rgb), 32'h6);
    req = '0;
    @(negedge clk); check("d0_gap", 32'(rgb), 32'h0); check("d0_done", 32'(done), 32'h1);
    @(negedge clk); check("d0_ret", 32'(rgb), 32'h2); check("d0_busy", 32'(busy), 32'h0);

    // Reset in the second SHOW cycle of a dwell-5 display.
    req[3] = 1'b1; req_color[11:9] = 3'b011; req_dwell[31:24] = 8'd5;
    @(negedge clk); check("rs_grant", 32'(grant), 32'h8);
    req = '0;
    @(negedge clk);
    snap  = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("rs_rgb",   32'(rgb),   32'h7);
    check("rs_busy",  32'(busy),  32'h0);
    check("rs_owner", 32'(owner), 32'h0);
    check("rs_done",  32'(done),  32'h0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("rs_nodone", 32'(done_cnt), 32'(snap));
    req[1] = 1'b1; req_color[5:3] = 3'b001; req_dwell[15:8] = 8'd1;
    @(negedge clk); check("rs_g1", 32'(grant), 32'h2); check("rs_o1", 32'(owner), 32'h1);
    req = '0;
    @(negedge clk); check("rs_d1", 32'(done), 32'h2);
    repeat (2) @(negedge clk);

    // Round robin from a fresh pointer with all four requesting, dwell 2.
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    req_dwell = {4{8'd2}};
    req_color = {3'b100, 3'b011, 3'b010, 3'b001};
    g_idx.delete(); g_cyc.delete();
    req = 4'b1111;
    repeat (14) @(negedge clk);
    req = '0;
    repeat (4) @(negedge clk);
    check("rr_count", 32'(g_idx.size()), 32'd5);
    if (g_idx.size() >= 5) begin
      check("rr_g0", 32'(g_idx[0]), 32'd0);
      check("rr_g1", 32'(g_idx[1]), 32'd1);
      check("rr_g2", 32'(g_idx[2]), 32'd2);
      check("rr_g3", 32'(g_idx[3]), 32'd3);
      check("rr_g4", 32'(g_idx[4]), 32'd0);
      for (int i = 1; i < 5; i++) check("rr_period", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
    end

    // Pointer at 3: serve 2, then 1001 pending, then 1 rises during 3's display.
    g_idx.delete(); g_cyc.delete();
    req = 4'b0100;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (grant == 4'b0100) req = req | 4'b1001;
      if (grant == 4'b1000) req[1] = 1'b1;
      req = req & ~grant;
    end
    req = '0;
    check("sim_count", 32'(g_idx.size()), 32'd4);
    if (g_idx.size() >= 4) begin
      check("sim_g0", 32'(g_idx[0]), 32'd2);
      check("sim_g1", 32'(g_idx[1]), 32'd3);
      check("sim_g2", 32'(g_idx[2]), 32'd0);
      check("sim_g3", 32'(g_idx[3]), 32'd1);
    end

    // Randomized traffic with idle stretches, drops, data churn and rare resets.
    pend = '0;
    rate = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 200 == 0) rate = int'($urandom_range(0, 4));
      pend = pend & ~grant;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (int'($urandom_range(0, 15)) < rate) pend[i] = 1'b1;
      if ($urandom_range(0, 63) == 0) pend[$urandom_range(0, NREQ-1)] = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = int'($urandom_range(0, NREQ-1));
        req_color[i*3 +: 3] = 3'($urandom);
        req_dwell[i*DWELL_W +: DWELL_W] = ($urandom_range(0, 7) == 0) ?
          8'($urandom_range(0, 20)) : 8'($urandom_range(0, 4));
      end
      req = pend;
    end
    req = '0;
    repeat (30) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_light_scheduler.md
Name: rgb_light_scheduler

Overview:
- Shares the single RGB light output between NREQ requesters.
- Each requester asks to show a 3-bit colour for a programmable number of cycles.
- Grants are round-robin. Each display ends with a one-cycle blank gap.
- When no one is requesting, the light runs the standard 8-step idle colour sequence from a prescaled 3-bit counter.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWELL_W, 8, width of each dwell field.
- IDLE_DIV, 16, clk cycles per idle-sequence step (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req  in  NREQ  request, one bit per requester; level, held until granted.
- req_color  in  3*NREQ  colour of requester i at bits [3i+2:3i].
- req_dwell  in  DWELL_W*NREQ  display length in cycles for requester i; 0 is treated as 1.
- grant  out  NREQ  one-hot, one-cycle pulse: request accepted.
- done  out  NREQ  one-hot, one-cycle pulse: display finished.
- busy  out  1  high in SHOW and GAP.
- owner  out  $clog2(NREQ)  index of the current or last granted requester.
- rgb  out  3  registered light drive, {r,g,b}.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, rgb=3'b111 (idle step 0), grant=0, done=0, busy=0, owner=0, rr pointer=0, idle_cnt=0, prescaler=0.
- Reset has priority over everything. A reset mid-SHOW aborts the display with no done pulse.
- Idle colour table, idle_cnt -> rgb: 0->111, 1->010, 2->011, 3->100, 4->110, 5->101, 6->001, 7->000.
- States: IDLE, SHOW, GAP.
- Arbitration runs at the edge ending any IDLE or GAP cycle in which req!=0:
  - Winner = first set req bit at or after rr pointer, wrapping modulo NREQ.
  - At that edge: state->SHOW; grant[winner]=1 for the next cycle only; owner=winner; colour and dwell latched; rgb=colour; busy=1; rr pointer=(winner+1) mod NREQ.
- Requester data is sampled only at the arbitration edge. Later changes to req_color/req_dwell or deassertion of req have no effect on the current display.
- SHOW lasts exactly D=max(dwell,1) cycles with rgb=latched colour.
- At the edge ending the last SHOW cycle: state->GAP; rgb=000; done[owner]=1 for that GAP cycle only.
- GAP lasts exactly one cycle.
  - If req!=0, arbitrate: back-to-back displays are separated by exactly one blank cycle.
  - Otherwise state->IDLE, busy=0, rgb=table[idle_cnt].
- IDLE:
  - rgb=table[idle_cnt] at all times.
  - prescaler counts 0..IDLE_DIV-1. On wrap, idle_cnt increments, 7 wraps to 0.
  - On leaving IDLE, idle_cnt is frozen and prescaler clears. Re-entering IDLE resumes the sequence at the frozen step, with a full IDLE_DIV period before the next step.
  - If req rises in IDLE, grant appears in the cycle after req is first sampled high (1-cycle request-to-grant latency).
- A requester still asserting req after being served competes again. The pointer guarantees every other pending requester is served first (no starvation; worst-case wait NREQ-1 displays).
- A req bit that drops before being sampled is never granted.
- At most one grant bit and one done bit are high in any cycle. grant and done are never high together (SHOW>=1 cycle).

Decomposition:
- Package rgb_sched_pkg holds:
  - state encoding (IDLE=0, SHOW=1, GAP=2);
  - IDLE_COLORS constant, 8 x 3-bit, per the table above;
  - the rgb blank constant 3'b000.
- Sub-module rr_arbiter (NREQ param): inputs req, ptr; outputs valid, winner index. Purely combinational.
- FSM, dwell counter, idle prescaler and idle counter live in the top.

Test Plan:
- Reset then idle, IDLE_DIV=4, no req: rgb steps 111,010,011,100,110,101,001,000,111, changing every 4 cycles; busy=0 throughout.
- Single request: req[2]=1, color=101, dwell=3 in IDLE:
  - next cycle grant=0100, owner=2, rgb=101 for 3 cycles;
  - then one cycle rgb=000 with done=0100;
  - then IDLE resumes at the frozen step.
- Dwell 0: req[0]=1, dwell=0, color=110 -> rgb=110 for exactly 1 cycle, then GAP with done=0001.
- Round-robin: req=1111 held continuously, all dwell=2 -> grant order 0,1,2,3,0. Each pair of grants is separated by 2 SHOW cycles + 1 GAP (a 3-cycle period).
- Simultaneous, pointer at 3: after serving 2, req=1001 -> grant 3 then 0. req[1] rising mid-SHOW is served after 0 if the pointer reaches it.
- Reset mid-SHOW (cycle 2 of dwell=5) -> next cycle rgb=111, busy=0, no done pulse, owner=0. A later req[1] is granted normally.
